// File: rtl/sram_arbiter_if.sv
// Client and SRAM command bundle for sram_arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface sram_arbiter_if;
    logic        w0_din_ready;
    logic        w0_din_valid;
    logic [53:0] w0_din;
    logic        w1_din_ready;
    logic        w1_din_valid;
    logic [53:0] w1_din;
    logic        r0_din_ready;
    logic        r0_din_valid;
    logic [17:0] r0_din;
    logic        r0_dout_ready;
    logic        r0_dout_valid;
    logic [31:0] r0_dout;
    logic        r1_din_ready;
    logic        r1_din_valid;
    logic [17:0] r1_din;
    logic        r1_dout_ready;
    logic        r1_dout_valid;
    logic [31:0] r1_dout;
    logic        sram_addr_valid;
    logic        sram_ready;
    logic [17:0] sram_addr;
    logic [31:0] sram_data_in;
    logic [3:0]  sram_write_mask;
    logic [31:0] sram_data_out;
    logic        sram_data_out_valid;

    modport master (
        output w0_din_ready, input w0_din_valid, input w0_din,
        output w1_din_ready, input w1_din_valid, input w1_din,
        output r0_din_ready, input r0_din_valid, input r0_din,
        input r0_dout_ready, output r0_dout_valid, output r0_dout,
        output r1_din_ready, input r1_din_valid, input r1_din,
        input r1_dout_ready, output r1_dout_valid, output r1_dout,
        output sram_addr_valid, input sram_ready, output sram_addr,
        output sram_data_in, output sram_write_mask,
        input sram_data_out, input sram_data_out_valid
    );

    modport slave (
        input w0_din_ready, output w0_din_valid, output w0_din,
        input w1_din_ready, output w1_din_valid, output w1_din,
        input r0_din_ready, output r0_din_valid, output r0_din,
        output r0_dout_ready, input r0_dout_valid, input r0_dout,
        input r1_din_ready, output r1_din_valid, output r1_din,
        output r1_dout_ready, input r1_dout_valid, input r1_dout,
        input sram_addr_valid, output sram_ready, input sram_addr,
        input sram_data_in, input sram_write_mask,
        output sram_data_out, output sram_data_out_valid
    );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter of two write and two read clients onto one pipelined SRAM port,
// with per-client request FIFOs, per-reader response FIFOs and in-order return steering.

// Show-ahead FIFO; dout reads as zero while empty.
module sram_arbiter_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign dout    = (count == '0) ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

module sram_arbiter #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic          sram_clock,
    input  logic          reset,
    output logic [2:0]    theState,
    sram_arbiter_if.master bus
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TW = $clog2(2 * FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ST_W0 = 3'd1,
        ST_W1 = 3'd2,
        ST_R0 = 3'd3,
        ST_R1 = 3'd4
    } state_t;

    state_t        state;
    logic [1:0]    last_grant;
    logic [1:0]    sel;
    logic [1:0]    cand;
    logic          any_elig;
    logic          grant;
    logic [3:0]    elig;
    logic [3:0]    req_pop;
    logic [53:0]   w_head [2];
    logic [17:0]   r_head [2];
    logic [CW-1:0] req_cnt [4];
    logic [CW-1:0] resp_cnt [2];
    logic [CW-1:0] out_cnt [2];
    logic [TW-1:0] tag_cnt;
    logic          tag_head;
    logic          ret_valid;
    logic [1:0]    issue_rd;
    logic [1:0]    resp_push;
    logic          cmd_valid;
    logic [17:0]   cmd_addr;
    logic [31:0]   cmd_data;
    logic [3:0]    cmd_mask;

    sram_arbiter_fifo #(.WIDTH(54), .DEPTH(FIFO_DEPTH)) u_w0_req (
        .clk(sram_clock), .rst(reset), .push(bus.w0_din_valid && bus.w0_din_ready),
        .din(bus.w0_din), .pop(req_pop[0]), .dout(w_head[0]), .count(req_cnt[0]));
    sram_arbiter_fifo #(.WIDTH(54), .DEPTH(FIFO_DEPTH)) u_w1_req (
        .clk(sram_clock), .rst(reset), .push(bus.w1_din_valid && bus.w1_din_ready),
        .din(bus.w1_din), .pop(req_pop[1]), .dout(w_head[1]), .count(req_cnt[1]));
    sram_arbiter_fifo #(.WIDTH(18), .DEPTH(FIFO_DEPTH)) u_r0_req (
        .clk(sram_clock), .rst(reset), .push(bus.r0_din_valid && bus.r0_din_ready),
        .din(bus.r0_din), .pop(req_pop[2]), .dout(r_head[0]), .count(req_cnt[2]));
    sram_arbiter_fifo #(.WIDTH(18), .DEPTH(FIFO_DEPTH)) u_r1_req (
        .clk(sram_clock), .rst(reset), .push(bus.r1_din_valid && bus.r1_din_ready),
        .din(bus.r1_din), .pop(req_pop[3]), .dout(r_head[1]), .count(req_cnt[3]));

    assign bus.w0_din_ready = (req_cnt[0] != CW'(FIFO_DEPTH));
    assign bus.w1_din_ready = (req_cnt[1] != CW'(FIFO_DEPTH));
    assign bus.r0_din_ready = (req_cnt[2] != CW'(FIFO_DEPTH));
    assign bus.r1_din_ready = (req_cnt[3] != CW'(FIFO_DEPTH));

    // Issue-order port tags; deep enough for every read that credits allow in flight.
    sram_arbiter_fifo #(.WIDTH(1), .DEPTH(2 * FIFO_DEPTH)) u_tag (
        .clk(sram_clock), .rst(reset), .push(issue_rd[0] || issue_rd[1]),
        .din(sel[0]), .pop(ret_valid), .dout(tag_head), .count(tag_cnt));

    assign ret_valid    = bus.sram_data_out_valid && (tag_cnt != '0);
    assign resp_push[0] = ret_valid && !tag_head;
    assign resp_push[1] = ret_valid && tag_head;

    sram_arbiter_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_r0_resp (
        .clk(sram_clock), .rst(reset), .push(resp_push[0]), .din(bus.sram_data_out),
        .pop(bus.r0_dout_ready && bus.r0_dout_valid), .dout(bus.r0_dout), .count(resp_cnt[0]));
    sram_arbiter_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_r1_resp (
        .clk(sram_clock), .rst(reset), .push(resp_push[1]), .din(bus.sram_data_out),
        .pop(bus.r1_dout_ready && bus.r1_dout_valid), .dout(bus.r1_dout), .count(resp_cnt[1]));

    assign bus.r0_dout_valid = (resp_cnt[0] != '0);
    assign bus.r1_dout_valid = (resp_cnt[1] != '0);

    // A reader holds a credit while in-flight reads plus buffered responses stay below depth.
    always_comb begin
        elig[0] = (req_cnt[0] != '0);
        elig[1] = (req_cnt[1] != '0);
        elig[2] = (req_cnt[2] != '0) &&
                  ((CW+1)'(out_cnt[0]) + (CW+1)'(resp_cnt[0]) < (CW+1)'(FIFO_DEPTH));
        elig[3] = (req_cnt[3] != '0) &&
                  ((CW+1)'(out_cnt[1]) + (CW+1)'(resp_cnt[1]) < (CW+1)'(FIFO_DEPTH));
    end

    always_comb begin
        any_elig = 1'b0;
        sel      = last_grant;
        cand     = '0;
        for (int i = 1; i <= 4; i++) begin
            cand = last_grant + 2'(i);
            if (!any_elig && elig[cand]) begin
                any_elig = 1'b1;
                sel      = cand;
            end
        end
    end

    assign grant       = any_elig && bus.sram_ready;
    assign req_pop     = grant ? (4'b0001 << sel) : 4'b0000;
    assign issue_rd[0] = grant && (sel == 2'd2);
    assign issue_rd[1] = grant && (sel == 2'd3);

    always_ff @(posedge sram_clock) begin
        if (reset) begin
            out_cnt[0] <= '0;
            out_cnt[1] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                out_cnt[k] <= out_cnt[k] + CW'(issue_rd[k]) - CW'(resp_push[k]);
            end
        end
    end

    // Arbiter state and registered SRAM command.
    always_ff @(posedge sram_clock) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 2'd3;
            cmd_valid  <= 1'b0;
            cmd_addr   <= '0;
            cmd_data   <= '0;
            cmd_mask   <= '0;
        end else if (grant) begin
            last_grant <= sel;
            cmd_valid  <= 1'b1;
            case (sel)
                2'd0: begin
                    state    <= ST_W0;
                    cmd_addr <= w_head[0][49:32];
                    cmd_data <= w_head[0][31:0];
                    cmd_mask <= w_head[0][53:50];
                end
                2'd1: begin
                    state    <= ST_W1;
                    cmd_addr <= w_head[1][49:32];
                    cmd_data <= w_head[1][31:0];
                    cmd_mask <= w_head[1][53:50];
                end
                2'd2: begin
                    state    <= ST_R0;
                    cmd_addr <= r_head[0];
                    cmd_data <= '0;
                    cmd_mask <= '0;
                end
                default: begin
                    state    <= ST_R1;
                    cmd_addr <= r_head[1];
                    cmd_data <= '0;
                    cmd_mask <= '0;
                end
            endcase
        end else begin
            state     <= IDLE;
            cmd_valid <= 1'b0;
            cmd_addr  <= '0;
            cmd_data  <= '0;
            cmd_mask  <= '0;
        end
    end

    assign theState            = state;
    assign bus.sram_addr_valid = cmd_valid;
    assign bus.sram_addr       = cmd_addr;
    assign bus.sram_data_in    = cmd_data;
    assign bus.sram_write_mask = cmd_mask;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed vector table, hand sequences for multi-cycle corners,
// then randomized traffic against a queue-based reference model.
module tb_sram_arbiter;
    localparam int D = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] the_state;

    sram_arbiter_if bus();

    sram_arbiter #(.FIFO_DEPTH(D)) dut (
        .sram_clock(clk),
        .reset(reset),
        .theState(the_state),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model state
    logic [53:0] wq0[$], wq1[$];
    logic [17:0] rq0[$], rq1[$];
    logic [31:0] resp0[$], resp1[$];
    bit          m_tag[$];
    int          m_out[2];
    int          m_last;
    logic [2:0]  m_state;
    logic [17:0] m_addr;
    logic [31:0] m_data;
    logic [3:0]  m_mask;
    bit          m_issue_rd;

    task automatic model_edge();
        bit   elig[4];
        bit   pw0, pw1, pr0, pr1, pop0, pop1, ret, t;
        int   g, p;
        logic [53:0] w;
        m_issue_rd = 0;
        if (reset) begin
            wq0.delete(); wq1.delete(); rq0.delete(); rq1.delete();
            resp0.delete(); resp1.delete(); m_tag.delete();
            m_out[0] = 0; m_out[1] = 0; m_last = 3;
            m_state = 0; m_addr = 0; m_data = 0; m_mask = 0;
            return;
        end
        pw0  = bus.w0_din_valid && (wq0.size() < D);
        pw1  = bus.w1_din_valid && (wq1.size() < D);
        pr0  = bus.r0_din_valid && (rq0.size() < D);
        pr1  = bus.r1_din_valid && (rq1.size() < D);
        pop0 = bus.r0_dout_ready && (resp0.size() > 0);
        pop1 = bus.r1_dout_ready && (resp1.size() > 0);
        ret  = bus.sram_data_out_valid && (m_tag.size() > 0);
        elig[0] = wq0.size() > 0;
        elig[1] = wq1.size() > 0;
        elig[2] = (rq0.size() > 0) && (m_out[0] + resp0.size() < D);
        elig[3] = (rq1.size() > 0) && (m_out[1] + resp1.size() < D);
        g = -1;
        if (bus.sram_ready) begin
            for (int i = 1; i <= 4; i++) begin
                p = (m_last + i) % 4;
                if (g < 0 && elig[p]) g = p;
            end
        end
        if (pop0) void'(resp0.pop_front());
        if (pop1) void'(resp1.pop_front());
        if (ret) begin
            t = m_tag.pop_front();
            m_out[t]--;
            if (t == 0) resp0.push_back(bus.sram_data_out);
            else        resp1.push_back(bus.sram_data_out);
        end
        case (g)
            0: begin w = wq0.pop_front(); m_state = 1; m_addr = w[49:32]; m_data = w[31:0]; m_mask = w[53:50]; end
            1: begin w = wq1.pop_front(); m_state = 2; m_addr = w[49:32]; m_data = w[31:0]; m_mask = w[53:50]; end
            2: begin m_state = 3; m_addr = rq0.pop_front(); m_data = 0; m_mask = 0;
                     m_tag.push_back(0); m_out[0]++; m_issue_rd = 1; end
            3: begin m_state = 4; m_addr = rq1.pop_front(); m_data = 0; m_mask = 0;
                     m_tag.push_back(1); m_out[1]++; m_issue_rd = 1; end
            default: begin m_state = 0; m_addr = 0; m_data = 0; m_mask = 0; end
        endcase
        if (g >= 0) m_last = g;
        if (pw0) wq0.push_back(bus.w0_din);
        if (pw1) wq1.push_back(bus.w1_din);
        if (pr0) rq0.push_back(bus.r0_din);
        if (pr1) rq1.push_back(bus.r1_din);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.w0_din_valid = 0; bus.w0_din = '0;
        bus.w1_din_valid = 0; bus.w1_din = '0;
        bus.r0_din_valid = 0; bus.r0_din = '0;
        bus.r1_din_valid = 0; bus.r1_din = '0;
        bus.r0_dout_ready = 0; bus.r1_dout_ready = 0;
        bus.sram_ready = 1;
        bus.sram_data_out_valid = 0; bus.sram_data_out = '0;
    endtask

    task automatic do_reset(input int n);
        reset = 1;
        for (int i = 0; i < n; i++) begin
            model_edge();
            step();
        end
        reset = 0;
    endtask

    function automatic logic [63:0] cmd_now();
        return 64'({bus.sram_addr_valid, bus.sram_addr, bus.sram_data_in, bus.sram_write_mask});
    endfunction

    function automatic logic [63:0] ready_now();
        return 64'({bus.w0_din_ready, bus.w1_din_ready, bus.r0_din_ready, bus.r1_din_ready});
    endfunction

    // Directed round-robin vectors: input valid on all ports, expected command after the edge.
    typedef struct {
        logic        vld;
        logic [2:0]  st;
        logic [17:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } rr_vec_t;
    rr_vec_t rr_tab[11];

    // Directed backpressure SRAM responder state
    logic [31:0] bp_pend[$];
    int bp_pushed, bp_issued;

    task automatic bp_cycle();
        bit acc;
        if (bp_pend.size() > 0) begin
            bus.sram_data_out_valid = 1;
            bus.sram_data_out = bp_pend.pop_front();
        end else begin
            bus.sram_data_out_valid = 0;
        end
        bus.r0_din_valid = (bp_pushed < D + 2);
        bus.r0_din = 18'(bp_pushed);
        acc = bus.r0_din_valid && bus.r0_din_ready;
        step();
        if (acc) bp_pushed++;
        if (bus.sram_addr_valid && the_state == 3'd3) begin
            bp_issued++;
            bp_pend.push_back(32'h100 + 32'(bus.sram_addr));
        end
    endtask

    typedef struct {
        logic [31:0] data;
        int          due;
    } pend_t;
    pend_t pend[$];

    initial begin
        rr_tab[0]  = '{1'b1, 3'd0, 18'd0, 32'd0, 4'h0};
        rr_tab[1]  = '{1'b1, 3'd1, 18'd0, 32'd0, 4'hF};
        rr_tab[2]  = '{1'b0, 3'd2, 18'd1, 32'd1, 4'hF};
        rr_tab[3]  = '{1'b0, 3'd3, 18'd3, 32'd0, 4'h0};
        rr_tab[4]  = '{1'b0, 3'd4, 18'd4, 32'd0, 4'h0};
        rr_tab[5]  = '{1'b0, 3'd1, 18'd0, 32'd0, 4'hF};
        rr_tab[6]  = '{1'b0, 3'd2, 18'd1, 32'd1, 4'hF};
        rr_tab[7]  = '{1'b0, 3'd3, 18'd3, 32'd0, 4'h0};
        rr_tab[8]  = '{1'b0, 3'd4, 18'd4, 32'd0, 4'h0};
        rr_tab[9]  = '{1'b0, 3'd0, 18'd0, 32'd0, 4'h0};
        rr_tab[10] = '{1'b0, 3'd0, 18'd0, 32'd0, 4'h0};

        clear_inputs();
        do_reset(3);
        chk("reset_state", 64'(the_state), 64'd0);
        chk("reset_cmd", cmd_now(), 64'd0);
        chk("reset_din_ready", ready_now(), 64'hF);
        chk("reset_r0_out", 64'({bus.r0_dout_valid, bus.r0_dout}), 64'd0);
        chk("reset_r1_out", 64'({bus.r1_dout_valid, bus.r1_dout}), 64'd0);

        // Round-robin fill
        bus.w0_din = {4'hF, 18'd0, 32'd0};
        bus.w1_din = {4'hF, 18'd1, 32'd1};
        bus.r0_din = 18'd3;
        bus.r1_din = 18'd4;
        for (int i = 0; i < 11; i++) begin
            bus.w0_din_valid = rr_tab[i].vld;
            bus.w1_din_valid = rr_tab[i].vld;
            bus.r0_din_valid = rr_tab[i].vld;
            bus.r1_din_valid = rr_tab[i].vld;
            step();
            chk($sformatf("rr_state[%0d]", i), 64'(the_state), 64'(rr_tab[i].st));
            chk($sformatf("rr_cmd[%0d]", i), cmd_now(),
                64'({rr_tab[i].st != 3'd0, rr_tab[i].addr, rr_tab[i].data, rr_tab[i].mask}));
        end

        // Read steering: tags are R0, R1, R0, R1
        bus.sram_data_out_valid = 1; bus.sram_data_out = 32'd1;
        step();
        chk("steer_first_r0", 64'({bus.r0_dout_valid, bus.r0_dout}), 64'({1'b1, 32'd1}));
        chk("steer_first_r1", 64'(bus.r1_dout_valid), 64'd0);
        bus.sram_data_out = 32'd2; step();
        bus.sram_data_out_valid = 0; step();
        bus.sram_data_out_valid = 1; bus.sram_data_out = 32'd3; step();
        bus.sram_data_out = 32'd4; step();
        bus.sram_data_out_valid = 0;
        step(); step();
        chk("hold_r0", 64'({bus.r0_dout_valid, bus.r0_dout}), 64'({1'b1, 32'd1}));
        chk("hold_r1", 64'({bus.r1_dout_valid, bus.r1_dout}), 64'({1'b1, 32'd2}));
        bus.r0_dout_ready = 1; bus.r1_dout_ready = 1;
        step();
        chk("adv_r0", 64'({bus.r0_dout_valid, bus.r0_dout}), 64'({1'b1, 32'd3}));
        chk("adv_r1", 64'({bus.r1_dout_valid, bus.r1_dout}), 64'({1'b1, 32'd4}));
        step();
        bus.r0_dout_ready = 0; bus.r1_dout_ready = 0;
        chk("drained_valid", 64'({bus.r0_dout_valid, bus.r1_dout_valid}), 64'd0);
        step();
        chk("drained_stays", 64'({bus.r0_dout_valid, bus.r1_dout_valid}), 64'd0);
        // A return with no read in flight is dropped
        bus.sram_data_out_valid = 1; bus.sram_data_out = 32'd99;
        step();
        bus.sram_data_out_valid = 0;
        chk("orphan_return", 64'({bus.r0_dout_valid, bus.r1_dout_valid}), 64'd0);

        // Backpressure on R0 response credits
        do_reset(1);
        bp_pushed = 0; bp_issued = 0; bp_pend.delete();
        for (int i = 0; i < 40; i++) bp_cycle();
        chk("bp_issued", 64'(bp_issued), 64'(D));
        chk("bp_pushed", 64'(bp_pushed), 64'(D + 2));
        chk("bp_head", 64'({bus.r0_dout_valid, bus.r0_dout}), 64'({1'b1, 32'h100}));
        bus.r0_dout_ready = 1;
        bp_cycle();
        bus.r0_dout_ready = 0;
        for (int i = 0; i < 20; i++) bp_cycle();
        chk("bp_issued_after_drain", 64'(bp_issued), 64'(D + 1));
        chk("bp_head_after_drain", 64'({bus.r0_dout_valid, bus.r0_dout}), 64'({1'b1, 32'h101}));
        bus.sram_data_out_valid = 0;
        bus.r0_din_valid = 0;

        // Reset with reads in flight
        do_reset(1);
        bus.r0_din = 18'd7; bus.r1_din = 18'd8;
        bus.r0_din_valid = 1; bus.r1_din_valid = 1; step();
        bus.r1_din_valid = 0; step();
        bus.r0_din_valid = 0;
        step(); step(); step();
        do_reset(1);
        chk("midrst_state", 64'(the_state), 64'd0);
        chk("midrst_cmd", cmd_now(), 64'd0);
        bus.sram_data_out_valid = 1; bus.sram_data_out = 32'd55; step();
        bus.sram_data_out_valid = 0; step();
        chk("midrst_late_return", 64'({bus.r0_dout_valid, bus.r1_dout_valid}), 64'd0);
        bus.r1_din = 18'd5; bus.r1_din_valid = 1; step();
        bus.r1_din_valid = 0; step(); step();
        bus.sram_data_out_valid = 1; bus.sram_data_out = 32'd77; step();
        bus.sram_data_out_valid = 0;
        chk("midrst_fresh_r1", 64'({bus.r1_dout_valid, bus.r1_dout}), 64'({1'b1, 32'd77}));
        chk("midrst_fresh_r0", 64'(bus.r0_dout_valid), 64'd0);

        // Randomized traffic against the reference model
        clear_inputs();
        do_reset(2);
        pend.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit slow = ((cyc / 250) % 2) == 1;
            reset = (cyc == 1700);
            bus.w0_din_valid = 1'($urandom_range(0, 1));
            bus.w1_din_valid = 1'($urandom_range(0, 1));
            bus.r0_din_valid = 1'($urandom_range(0, 1));
            bus.r1_din_valid = 1'($urandom_range(0, 1));
            bus.w0_din = {22'($urandom), $urandom};
            bus.w1_din = {22'($urandom), $urandom};
            bus.r0_din = 18'($urandom);
            bus.r1_din = 18'($urandom);
            bus.r0_dout_ready = slow ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            bus.r1_dout_ready = slow ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            bus.sram_ready = ($urandom_range(0, 9) < 8);
            if (pend.size() > 0 && pend[0].due <= cyc && $urandom_range(0, 2) != 0) begin
                bus.sram_data_out_valid = 1;
                bus.sram_data_out = pend[0].data;
                void'(pend.pop_front());
            end else if (m_tag.size() == 0 && $urandom_range(0, 9) == 0) begin
                bus.sram_data_out_valid = 1;
                bus.sram_data_out = $urandom;
            end else begin
                bus.sram_data_out_valid = 0;
                bus.sram_data_out = $urandom;
            end
            model_edge();
            if (reset) pend.delete();
            if (m_issue_rd) pend.push_back('{$urandom, cyc + 2});
            step();
            chk("rnd_state", 64'(the_state), 64'(m_state));
            chk("rnd_cmd", cmd_now(), 64'({m_state != 3'd0, m_addr, m_data, m_mask}));
            chk("rnd_din_ready", ready_now(),
                64'({wq0.size() < D, wq1.size() < D, rq0.size() < D, rq1.size() < D}));
            chk("rnd_r0_out", 64'({bus.r0_dout_valid, bus.r0_dout}),
                64'({resp0.size() > 0, (resp0.size() > 0) ? resp0[0] : 32'd0}));
            chk("rnd_r1_out", 64'({bus.r1_dout_valid, bus.r1_dout}),
                64'({resp1.size() > 0, (resp1.size() > 0) ? resp1[0] : 32'd0}));
        end
        reset = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Single-clock arbiter that multiplexes two write ports (W0 image-buffer writer, W1 overlay writer) and two read ports (R0 image-buffer reader, R1 reader) onto one pipelined SRAM command interface. Each client port has its own request FIFO, and each read port has a response FIFO. Requests are granted round-robin, one SRAM command per cycle. Read data returning from the SRAM is steered back to the reader that issued it, in issue order.

## Interface
- `FIFO_DEPTH`, 8: entries in every request FIFO and every read-response FIFO; power of two, ≥2.
- `sram_clock` in 1: the single clock for the whole block and all ports.
- `reset` in 1: synchronous, active-high; empties every FIFO, clears all outstanding-read state, forces state to IDLE.
- `theState` out 3: current arbiter state: 0 IDLE, 1 W0, 2 W1, 3 R0, 4 R1.
- `w0_din_ready` out 1: W0 request FIFO not full.
- `w0_din_valid` in 1: W0 request present.
- `w0_din` in 54: W0 request, packed {mask[53:50], addr[49:32], data[31:0]}.
- `w1_din_ready`, `w1_din_valid`, `w1_din`: same as W0, for port W1.
- `r0_din_ready` out 1: R0 address FIFO not full.
- `r0_din_valid` in 1: R0 read request present.
- `r0_din` in 18: R0 read address.
- `r0_dout_ready` in 1: consumer accepts R0 data.
- `r0_dout_valid` out 1: R0 response FIFO not empty.
- `r0_dout` out 32: head of the R0 response FIFO (show-ahead).
- `r1_*`: same as R0, for port R1.
- `sram_addr_valid` out 1: a command is presented this cycle.
- `sram_ready` in 1: SRAM can accept a command.
- `sram_addr` out 18: command address.
- `sram_data_in` out 32: write data; 0 for reads.
- `sram_write_mask` out 4: byte write enables; 4'b0000 means read.
- `sram_data_out` in 32: returned read data.
- `sram_data_out_valid` in 1: `sram_data_out` carries one read return this cycle.

## Operation
- Push a request FIFO on `*_din_valid && *_din_ready`.
- Pop a response FIFO on `rX_dout_ready && rX_dout_valid`.
- Arbitration happens every edge when not in reset.
  - Round-robin order: W0 → W1 → R0 → R1 → W0.
  - The search starts at the port after the last granted port. After reset it starts at W0.
- A port is eligible when its request FIFO is non-empty. A read port must also have a credit: outstanding reads for that port plus its response-FIFO occupancy < `FIFO_DEPTH`.
- If `sram_ready` is 1 and some port is eligible:
  - the state register moves to that port's state;
  - the port's FIFO head is popped into the command registers.
- Otherwise the state goes to IDLE.
- Command outputs are registered and valid for exactly the cycle the state is non-IDLE.
  - `sram_addr_valid` = (state != IDLE).
  - W0/W1: `sram_addr`, `sram_data_in` and `sram_write_mask` come from the packed word.
  - R0/R1: `sram_addr` is the read address, `sram_write_mask` = 0, `sram_data_in` = 0.
  - IDLE: all command outputs are 0.
- Read return tracking:
  - Each issued read pushes its port ID (0 = R0, 1 = R1) into an in-order tag FIFO of depth 2×`FIFO_DEPTH`.
  - On each `sram_data_out_valid` the tag head is popped and `sram_data_out` is pushed into that reader's response FIFO.
  - A `sram_data_out_valid` pulse with the tag FIFO empty is ignored.
  - The SRAM returns read data in issue order with arbitrary latency ≥1 cycle.
- Mask nonzero with zero data is a legal write. A write with mask 0 on W0/W1 is forwarded unchanged.

## Timing
- Reset values:
  - `theState` = 0.
  - `sram_addr_valid`, `sram_addr`, `sram_data_in`, `sram_write_mask` all 0.
  - all `*_din_ready` = 1.
  - all `rX_dout_valid` = 0; `rX_dout` = 0.
- Request latency: a request accepted at edge N is eligible at edge N+1, so the earliest command is in the cycle after edge N+1.
- Throughput: one command per cycle while any port is eligible.
  - Four always-busy ports produce W0, W1, R0, R1, W0, … with no IDLE gaps.
- Response latency: a return at edge M makes `rX_dout_valid` = 1 after edge M.
- Return into a full response FIFO cannot occur, because the credit rule prevents it.
- Simultaneous events:
  - Push and pop on the same FIFO in one cycle are both honoured; occupancy is unchanged.
  - Issuing a read and receiving a return in the same cycle update the tag FIFO and credits consistently.
- `*_din_ready` deasserts the cycle after the FIFO reaches `FIFO_DEPTH` entries.
- Asserting `reset` mid-operation discards queued requests, in-flight tags and responses; the next cycle is IDLE.

## Test plan
- **Reset:** hold `reset` 3 cycles → all outputs at their reset values, `theState` = 0.
- **Round-robin fill:** 2 cycles of simultaneous valid on all ports with W0 = {F, 0, 0}, W1 = {F, 1, 1}, R0 addr 3, R1 addr 4 → commands W0(0, 0, F), W1(1, 1, F), R0(3, mask 0), R1(4, mask 0), then the same four again, then IDLE with `sram_addr_valid` = 0.
- **Read steering:** returns 1, 2, 3, 4 (one gap cycle allowed) → R0 receives 1 then 3; R1 receives 2 then 4.
- **Response handshake:** `dout_ready` low → data held with `dout_valid` = 1. Ready high for 2 cycles → data advances, then `dout_valid` = 0 on both readers and stays 0.
- **Backpressure:** R0 `dout_ready` = 0 with `FIFO_DEPTH` + 2 R0 requests → exactly `FIFO_DEPTH` R0 reads issued, then R0 is skipped. Draining one entry issues one more read.
- **Reset mid-operation:** reset asserted with reads in flight → a late `sram_data_out_valid` is ignored and `r0_dout_valid` = `r1_dout_valid` = 0.
